// File: rtl/subpel_vfilter_stream_pkg.sv
// Shared definitions for the sub-pel vertical filter stream.
//   - output sample width, accumulator width, tap count
//   - fractional-position and FSM state encodings
//   - per-phase coefficient tables (t0 = oldest row)
//   - cmul(): constant-coefficient multiply built only from shifts and adds
package subpel_vfilter_stream_pkg;

  localparam int unsigned OUT_W = 16;
  localparam int unsigned ACC_W = 20;
  localparam int unsigned NTAPS = 8;

  typedef enum logic [1:0] {
    FRAC_INT  = 2'd0,
    FRAC_Q1   = 2'd1,
    FRAC_HALF = 2'd2,
    FRAC_Q3   = 2'd3
  } frac_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FILL  = 2'd1,
    S_RUN   = 2'd2,
    S_FLUSH = 2'd3
  } state_e;

  localparam int COEF_Q1   [NTAPS] = '{-1, 4, -10, 58, 17, -5, 1, 0};
  localparam int COEF_HALF [NTAPS] = '{-1, 4, -11, 40, 40, -11, 4, -1};
  localparam int COEF_Q3   [NTAPS] = '{0, 1, -5, 17, 58, -10, 4, -1};

  // Every coefficient magnitude in the tables has a fixed shift/add form;
  // the sign is applied afterwards by negation.
  function automatic logic signed [ACC_W-1:0] cmul(input logic signed [ACC_W-1:0] x,
                                                   input int c);
    logic signed [ACC_W-1:0] m;
    int mag;
    mag = (c < 0) ? -c : c;
    case (mag)
      1:       m = x;
      4:       m = x <<< 2;
      5:       m = (x <<< 2) + x;
      10:      m = (x <<< 3) + (x <<< 1);
      11:      m = (x <<< 3) + (x <<< 1) + x;
      17:      m = (x <<< 4) + x;
      40:      m = (x <<< 5) + (x <<< 3);
      58:      m = (x <<< 6) - (x <<< 2) - (x <<< 1);
      default: m = '0;
    endcase
    return (c < 0) ? -m : m;
  endfunction

endpackage

// File: rtl/subpel_vfilter_stream_if.sv
// Row-stream bundle between a row source/sink and the vertical filter.
//   in_row/in_valid/in_ready     : reference rows in, pixel 0 in LSBs
//   out_row/out_valid/out_ready  : signed 16-bit filtered rows out
//   out_last                     : marks the final output row of a block
// master = source/sink side, slave = filter side.
interface subpel_vfilter_stream_if
  import subpel_vfilter_stream_pkg::*;
#(
  parameter int unsigned W        = 8,
  parameter int unsigned BITDEPTH = 8
);

  logic [W*BITDEPTH-1:0] in_row;
  logic                  in_valid;
  logic                  in_ready;
  logic [W*OUT_W-1:0]    out_row;
  logic                  out_valid;
  logic                  out_ready;
  logic                  out_last;

  modport master (
    output in_row, in_valid, out_ready,
    input  in_ready, out_row, out_valid, out_last
  );

  modport slave (
    input  in_row, in_valid, out_ready,
    output in_ready, out_row, out_valid, out_last
  );

endinterface

// File: rtl/subpel_vfilter_stream_fir8.sv
// One-pixel 8-tap vertical sub-pel filter (combinational).
//   taps_i : t0..t7 samples, t0 (oldest row) in LSBs, BITDEPTH bits each
//   frac_i : fractional phase
//   pix_o  : 16-bit result; integer phase is t3 scaled to 14-bit range,
//            other phases are the 20-bit signed sum shifted by BITDEPTH-8
module fir8_vtap
  import subpel_vfilter_stream_pkg::*;
#(
  parameter int unsigned BITDEPTH = 8
) (
  input  logic [NTAPS*BITDEPTH-1:0] taps_i,
  input  frac_e                     frac_i,
  output logic [OUT_W-1:0]          pix_o
);

  logic signed [ACC_W-1:0] x;
  logic signed [ACC_W-1:0] acc_q1;
  logic signed [ACC_W-1:0] acc_half;
  logic signed [ACC_W-1:0] acc_q3;
  logic signed [ACC_W-1:0] acc_sel;

  // All three phase sums are formed in parallel and selected afterwards so
  // each tap only ever sees constant coefficients.
  always_comb begin
    x        = '0;
    acc_q1   = '0;
    acc_half = '0;
    acc_q3   = '0;
    acc_sel  = '0;
    pix_o    = '0;
    for (int unsigned i = 0; i < NTAPS; i++) begin
      x = '0;
      x[BITDEPTH-1:0] = taps_i[i*BITDEPTH +: BITDEPTH];
      acc_q1   = acc_q1   + cmul(x, COEF_Q1[i]);
      acc_half = acc_half + cmul(x, COEF_HALF[i]);
      acc_q3   = acc_q3   + cmul(x, COEF_Q3[i]);
    end
    case (frac_i)
      FRAC_Q1:   acc_sel = acc_q1;
      FRAC_HALF: acc_sel = acc_half;
      FRAC_Q3:   acc_sel = acc_q3;
      default:   acc_sel = '0;
    endcase
    if (frac_i == FRAC_INT) begin
      pix_o = OUT_W'(taps_i[3*BITDEPTH +: BITDEPTH]) << (14 - BITDEPTH);
    end else begin
      pix_o = OUT_W'(acc_sel >>> (BITDEPTH - 8));
    end
  end

endmodule

// File: rtl/subpel_vfilter_stream.sv
// Streaming vertical sub-pel interpolation filter.
// A block is started in IDLE with a fractional phase and a height blk_h.
// The first 7 rows only prime the window; each further accepted row produces
// one filtered output row one cycle later, blk_h outputs per block.
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   start        : block start request (IDLE only)
//   frac, blk_h  : phase and output-row count, latched at start
//   busy         : high outside IDLE
//   start_err    : one-cycle pulse for a start with an out-of-range blk_h
//   blk_done     : one-cycle pulse after the final output handshake
//   bus          : row stream bundle (slave side)
module subpel_vfilter_stream
  import subpel_vfilter_stream_pkg::*;
#(
  parameter  int unsigned W        = 8,
  parameter  int unsigned BITDEPTH = 8,
  parameter  int unsigned MAX_H    = 64,
  localparam int unsigned HW       = $clog2(MAX_H + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [1:0]              frac,
  input  logic [HW-1:0]           blk_h,
  output logic                    busy,
  output logic                    start_err,
  output logic                    blk_done,
  subpel_vfilter_stream_if.slave  bus
);

  localparam int unsigned HIST = NTAPS - 1;

  state_e                state_q, state_d;
  frac_e                 frac_q;
  logic [HW-1:0]         blk_h_q;
  logic [2:0]            fill_cnt_q;
  logic [HW-1:0]         run_cnt_q;
  logic [W*BITDEPTH-1:0] hist_q [HIST];
  logic [W*OUT_W-1:0]    out_row_q;
  logic                  out_valid_q;
  logic                  out_last_q;
  logic                  start_err_q;
  logic                  blk_done_q;

  logic                  in_ready_c;
  logic                  go;
  logic                  reject;
  logic                  last_xfer;
  logic                  blk_ok;
  logic                  last_row;
  logic                  in_fire;
  logic                  run_fire;
  logic                  out_fire;
  logic [W*OUT_W-1:0]    filt_row;

  assign blk_ok   = (blk_h != '0) && (blk_h <= HW'(MAX_H));
  assign last_row = (run_cnt_q == blk_h_q - HW'(1));
  assign in_fire  = bus.in_valid && in_ready_c;
  assign run_fire = in_fire && (state_q == S_RUN);
  assign out_fire = out_valid_q && bus.out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    in_ready_c = 1'b0;
    go         = 1'b0;
    reject     = 1'b0;
    last_xfer  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (blk_ok) begin
            go      = 1'b1;
            state_d = S_FILL;
          end else begin
            reject = 1'b1;
          end
        end
      end
      S_FILL: begin
        in_ready_c = 1'b1;
        if (bus.in_valid && (fill_cnt_q == 3'd6)) begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        in_ready_c = !out_valid_q || bus.out_ready;
        if (bus.in_valid && in_ready_c && last_row) begin
          state_d = S_FLUSH;
        end
      end
      S_FLUSH: begin
        if (out_fire) begin
          last_xfer = 1'b1;
          state_d   = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // The window keeps the last 7 accepted rows; the incoming row is the eighth
  // (newest) tap, so the output register loads on the same edge it arrives.
  for (genvar p = 0; p < int'(W); p++) begin : g_pix
    logic [NTAPS*BITDEPTH-1:0] taps;
    always_comb begin
      taps = '0;
      for (int unsigned k = 0; k < HIST; k++) begin
        taps[k*BITDEPTH +: BITDEPTH] = hist_q[k][p*BITDEPTH +: BITDEPTH];
      end
      taps[HIST*BITDEPTH +: BITDEPTH] = bus.in_row[p*BITDEPTH +: BITDEPTH];
    end
    fir8_vtap #(.BITDEPTH(BITDEPTH)) u_fir (
      .taps_i (taps),
      .frac_i (frac_q),
      .pix_o  (filt_row[p*OUT_W +: OUT_W])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      frac_q      <= FRAC_INT;
      blk_h_q     <= '0;
      fill_cnt_q  <= '0;
      run_cnt_q   <= '0;
      out_row_q   <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      start_err_q <= 1'b0;
      blk_done_q  <= 1'b0;
      for (int unsigned k = 0; k < HIST; k++) begin
        hist_q[k] <= '0;
      end
    end else begin
      start_err_q <= reject;
      blk_done_q  <= last_xfer;
      if (go) begin
        frac_q     <= frac_e'(frac);
        blk_h_q    <= blk_h;
        fill_cnt_q <= '0;
        run_cnt_q  <= '0;
      end
      if (in_fire) begin
        for (int unsigned k = 0; k < HIST - 1; k++) begin
          hist_q[k] <= hist_q[k+1];
        end
        hist_q[HIST-1] <= bus.in_row;
      end
      if (in_fire && (state_q == S_FILL)) begin
        fill_cnt_q <= fill_cnt_q + 3'd1;
      end
      if (run_fire) begin
        out_row_q   <= filt_row;
        out_valid_q <= 1'b1;
        out_last_q  <= last_row;
        run_cnt_q   <= run_cnt_q + HW'(1);
      end else if (out_fire) begin
        out_valid_q <= 1'b0;
        out_last_q  <= 1'b0;
      end
    end
  end

  assign busy          = (state_q != S_IDLE);
  assign start_err     = start_err_q;
  assign blk_done      = blk_done_q;
  assign bus.in_ready  = in_ready_c && !rst;
  assign bus.out_row   = out_row_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_last  = out_last_q;

endmodule

// File: tb/tb_subpel_vfilter_stream.sv
module tb_subpel_vfilter_stream;

  localparam int W     = 8;
  localparam int BD    = 8;
  localparam int MAX_H = 64;
  localparam int HW    = $clog2(MAX_H + 1);
  localparam int OW    = W * 16;

  localparam int COEF [4][8] = '{
    '{0, 0, 0, 64, 0, 0, 0, 0},
    '{-1, 4, -10, 58, 17, -5, 1, 0},
    '{-1, 4, -11, 40, 40, -11, 4, -1},
    '{0, 1, -5, 17, 58, -10, 4, -1}
  };

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [1:0]    frac;
  logic [HW-1:0] blk_h;
  logic          busy;
  logic          start_err;
  logic          blk_done;

  subpel_vfilter_stream_if #(.W(W), .BITDEPTH(BD)) bus ();

  subpel_vfilter_stream #(.W(W), .BITDEPTH(BD), .MAX_H(MAX_H)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .frac      (frac),
    .blk_h     (blk_h),
    .busy      (busy),
    .start_err (start_err),
    .blk_done  (blk_done),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [W*BD-1:0] rows    [0:255];
  logic [OW-1:0]   exp_mem [0:127];
  logic [OW-1:0]   first_out;
  logic [OW-1:0]   last_out;

  task automatic check_eq(input string tag, input logic [OW-1:0] got, input logic [OW-1:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  // Output row k is the phase-weighted sum of input rows k..k+7.
  function automatic logic [OW-1:0] model_row(input int k, input int f);
    logic [OW-1:0] r;
    int acc;
    r = '0;
    for (int p = 0; p < W; p++) begin
      if (f == 0) begin
        acc = int'(rows[k+3][p*BD +: BD]) * (1 << (14 - BD));
      end else begin
        acc = 0;
        for (int j = 0; j < 8; j++) begin
          acc += COEF[f][j] * int'(rows[k+j][p*BD +: BD]);
        end
        acc = acc >>> (BD - 8);
      end
      r[p*16 +: 16] = acc[15:0];
    end
    return r;
  endfunction

  task automatic fill_const(input int v);
    for (int r = 0; r < 256; r++) rows[r] = {W{8'(v)}};
  endtask

  task automatic fill_ramp();
    for (int r = 0; r < 256; r++) rows[r] = {W{8'(r)}};
  endtask

  task automatic fill_step();
    for (int r = 0; r < 256; r++) rows[r] = (r < 4) ? '0 : {W{8'd255}};
  endtask

  task automatic fill_rand();
    for (int r = 0; r < 256; r++) begin
      for (int p = 0; p < W; p++) rows[r][p*BD +: BD] = 8'($urandom);
    end
  endtask

  // Drives one block of h outputs. rnd randomises valid/ready; stall_at holds
  // out_ready low 5 cycles once that many outputs are taken; abort_at resets
  // mid-block; inj_at issues a second start mid-block.
  task automatic run_block(input int f, input int h, input bit rnd,
                           input int stall_at, input int abort_at, input int inj_at);
    logic [OW-1:0] hold;
    int sent, got, cyc, tail, stall_left, dones, inj_state;
    bit stalled;
    sent = 0; got = 0; cyc = 0; tail = 0; stall_left = 0; dones = 0;
    inj_state = 0; stalled = 0; hold = '0;
    for (int k = 0; k < h; k++) exp_mem[k] = model_row(k, f);
    @(negedge clk);
    start = 1'b1; frac = 2'(f); blk_h = HW'(h);
    @(negedge clk);
    start = 1'b0;
    #1;
    check_eq("busy_after_start", OW'(busy), OW'(1));
    while (cyc < 4000 && tail < 4) begin
      @(negedge clk);
      cyc++;
      if (abort_at >= 0 && got == abort_at) begin
        rst = 1'b1; bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_eq("abort_busy", OW'(busy), '0);
        check_eq("abort_out_valid", OW'(bus.out_valid), '0);
        check_eq("abort_out_last", OW'(bus.out_last), '0);
        check_eq("abort_out_row", bus.out_row, '0);
        check_eq("abort_in_ready", OW'(bus.in_ready), '0);
        check_eq("abort_blk_done", OW'(blk_done), '0);
        return;
      end
      bus.in_valid  = (sent < h + 7) && (!rnd || $urandom_range(0, 3) != 0);
      bus.in_row    = bus.in_valid ? rows[sent] : '0;
      bus.out_ready = !rnd || $urandom_range(0, 3) != 0;
      if (stall_left == 0 && !stalled && stall_at >= 0 && got == stall_at && bus.out_valid) begin
        stall_left = 5; stalled = 1; hold = bus.out_row;
      end
      if (stall_left > 0) bus.out_ready = 1'b0;
      start = 1'b0;
      if (inj_state == 0 && inj_at >= 0 && got == inj_at) begin
        start = 1'b1; frac = ~2'(f); blk_h = HW'(3); inj_state = 1;
      end
      #1;
      if (inj_state == 2) begin
        check_eq("start_ignored_err", OW'(start_err), '0);
        inj_state = 3;
      end
      if (inj_state == 1) inj_state = 2;
      if (stall_left > 0) begin
        check_eq("stall_row_hold", bus.out_row, hold);
        check_eq("stall_in_ready", OW'(bus.in_ready), '0);
        stall_left--;
      end
      if (bus.out_valid && bus.out_ready) begin
        if (got < h) begin
          check_eq($sformatf("out_row[%0d]", got), bus.out_row, exp_mem[got]);
          check_eq($sformatf("out_last[%0d]", got), OW'(bus.out_last), OW'(got == h - 1));
        end else begin
          check_eq("out_count", OW'(got + 1), OW'(h));
        end
        if (got == 0) first_out = bus.out_row;
        last_out = bus.out_row;
        got++;
      end
      if (bus.in_valid && bus.in_ready) sent++;
      if (blk_done) dones++;
      if (got >= h) tail++;
    end
    bus.in_valid = 1'b0; bus.out_ready = 1'b0; start = 1'b0;
    check_eq("rows_sent", OW'(sent), OW'(h + 7));
    check_eq("outputs", OW'(got), OW'(h));
    check_eq("blk_done_count", OW'(dones), OW'(1));
    check_eq("busy_end", OW'(busy), '0);
  endtask

  task automatic try_bad_start(input int h);
    @(negedge clk);
    start = 1'b1; blk_h = HW'(h); frac = 2'd2;
    @(negedge clk);
    start = 1'b0;
    #1;
    check_eq($sformatf("start_err_h%0d", h), OW'(start_err), OW'(1));
    check_eq($sformatf("rej_busy_h%0d", h), OW'(busy), '0);
    @(negedge clk);
    #1;
    check_eq($sformatf("start_err_clr_h%0d", h), OW'(start_err), '0);
    check_eq($sformatf("rej_idle_h%0d", h), OW'(busy), '0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; frac = '0; blk_h = '0;
    bus.in_valid = 1'b0; bus.in_row = '0; bus.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    bus.in_valid = 1'b1;
    #1;
    check_eq("rst_in_ready", OW'(bus.in_ready), '0);
    @(negedge clk);
    rst = 1'b0; bus.in_valid = 1'b0;
    #1;
    check_eq("rst_busy", OW'(busy), '0);
    check_eq("rst_out_valid", OW'(bus.out_valid), '0);
    check_eq("rst_out_last", OW'(bus.out_last), '0);
    check_eq("rst_out_row", bus.out_row, '0);
    check_eq("rst_start_err", OW'(start_err), '0);
    check_eq("rst_blk_done", OW'(blk_done), '0);
    check_eq("idle_in_ready", OW'(bus.in_ready), '0);

    fill_const(100);
    run_block(2, 4, 0, -1, -1, -1);
    check_eq("flat_half_first", first_out, {W{16'h1900}});
    check_eq("flat_half_last", last_out, {W{16'h1900}});

    fill_ramp();
    run_block(0, 4, 0, -1, -1, -1);
    check_eq("int_first", first_out, {W{16'd192}});
    check_eq("int_last", last_out, {W{16'd384}});

    fill_step();
    run_block(1, 1, 0, -1, -1, -1);
    check_eq("step_q1", first_out, {W{16'd3315}});
    run_block(3, 1, 0, -1, -1, -1);

    try_bad_start(0);
    try_bad_start(MAX_H + 1);

    fill_rand();
    run_block(2, 10, 0, 3, -1, -1);
    fill_rand();
    run_block(1, 9, 1, 4, -1, -1);

    fill_rand();
    run_block(1, 6, 1, -1, -1, 2);

    fill_rand();
    run_block(3, 8, 0, -1, 3, -1);
    fill_rand();
    run_block(2, 5, 1, -1, -1, -1);

    fill_rand();
    run_block(3, MAX_H, 1, -1, -1, -1);

    for (int t = 0; t < 10; t++) begin
      fill_rand();
      run_block(int'($urandom_range(0, 3)), int'($urandom_range(1, 12)), 1, -1, -1, -1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
